// File: rtl/mem_stage_mc.sv
// Multi-cycle MEM stage: word-organised data memory with word/halfword/byte
// loads and stores, programmable wait states, a Stall request to the hazard
// unit and an error flag for illegal accesses (which never touch memory).
module mem_stage_mc #(
  parameter int DEPTH_LOG2  = 10,
  parameter int WAIT_STATES = 1
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_mem_read,
  input  logic        i_mem_write,
  input  logic [1:0]  i_byte_sel,
  input  logic        i_load_signed,
  input  logic [31:0] i_address,
  input  logic [31:0] i_write_data,
  output logic [31:0] o_read_data,
  output logic        o_stall,
  output logic        o_done,
  output logic        o_access_err
);

  localparam int         DEPTH = 1 << DEPTH_LOG2;
  localparam int         AW    = DEPTH_LOG2 + 2;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;
  localparam logic [2:0] WS_INIT = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

  // Illegal: read+write together, reserved size, misaligned, or beyond memory.
  function automatic logic f_illegal(input logic rd, input logic wr,
                                     input logic [1:0] bs, input logic [31:0] a);
    logic bad;
    bad = (rd & wr) | (bs == 2'b11) | ((bs == 2'b01) & a[0]) |
          ((bs == 2'b00) & (a[1:0] != 2'b00)) | ((a >> AW) != 32'd0);
    return bad;
  endfunction

  // Select the addressed lane of a word and sign/zero extend it.
  function automatic logic [31:0] f_load_lane(input logic [31:0] word, input logic [1:0] bs,
                                              input logic sgn, input logic [1:0] lane);
    logic [15:0] half;
    logic [7:0]  byt;
    logic [31:0] res;
    half = lane[1] ? word[31:16] : word[15:0];
    case (lane)
      2'd0:    byt = word[7:0];
      2'd1:    byt = word[15:8];
      2'd2:    byt = word[23:16];
      default: byt = word[31:24];
    endcase
    case (bs)
      2'b00:   res = word;
      2'b01:   res = {{16{sgn & half[15]}}, half};
      2'b10:   res = {{24{sgn & byt[7]}}, byt};
      default: res = 32'd0;
    endcase
    return res;
  endfunction

  // Byte enables of a store for the given size and lane.
  function automatic logic [3:0] f_store_be(input logic [1:0] bs, input logic [1:0] lane);
    logic [3:0] be;
    case (bs)
      2'b00:   be = 4'b1111;
      2'b01:   be = lane[1] ? 4'b1100 : 4'b0011;
      2'b10:   be = 4'b0001 << lane;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

  logic [1:0]    r_state;
  logic [1:0]    w_state_nxt;
  logic [2:0]    r_cnt;
  logic          r_done;
  logic          r_access_err;
  logic [31:0]   r_read_data;
  logic          r_rd, r_wr, r_sgn;
  logic [1:0]    r_bs;
  logic [AW-1:0] r_addr;
  logic [31:0]   r_wdata;
  logic [31:0]   r_mem [DEPTH];

  logic          w_req, w_ill_in, w_enter_done, w_commit_wr;
  logic          w_op_rd, w_op_wr, w_op_sgn, w_op_err;
  logic [1:0]    w_op_bs;
  logic [AW-1:0] w_op_addr;
  logic [31:0]   w_op_wdata, w_rword, w_load_val, w_store_data;
  logic [3:0]    w_store_be;
  logic [DEPTH_LOG2-1:0] w_op_idx;

  assign w_req    = i_mem_read | i_mem_write;
  assign w_ill_in = f_illegal(i_mem_read, i_mem_write, i_byte_sel, i_address);

  // Operands come straight from the inputs in IDLE (zero-wait path), else from the capture registers.
  always_comb begin
    w_op_rd    = r_rd;
    w_op_wr    = r_wr;
    w_op_bs    = r_bs;
    w_op_sgn   = r_sgn;
    w_op_addr  = r_addr;
    w_op_wdata = r_wdata;
    w_op_err   = 1'b0;
    if (r_state == ST_IDLE) begin
      w_op_rd    = i_mem_read;
      w_op_wr    = i_mem_write;
      w_op_bs    = i_byte_sel;
      w_op_sgn   = i_load_signed;
      w_op_addr  = i_address[AW-1:0];
      w_op_wdata = i_write_data;
      w_op_err   = w_ill_in;
    end else begin
      w_op_err   = 1'b0;
    end
  end

  // Next-state logic of the IDLE/WAIT/DONE access sequencer.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (!w_req) begin
          w_state_nxt = ST_IDLE;
        end else if (w_ill_in || (WAIT_STATES == 0)) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (r_cnt == 3'd0) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_state_nxt = ST_WAIT;
        end
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_op_idx     = w_op_addr[AW-1:2];
  assign w_rword      = r_mem[w_op_idx];
  assign w_load_val   = f_load_lane(w_rword, w_op_bs, w_op_sgn, w_op_addr[1:0]);
  assign w_store_be   = f_store_be(w_op_bs, w_op_addr[1:0]);
  assign w_store_data = (w_op_bs == 2'b00) ? w_op_wdata :
                        (w_op_bs == 2'b01) ? {2{w_op_wdata[15:0]}} : {4{w_op_wdata[7:0]}};
  assign w_enter_done = (r_state != ST_DONE) && (w_state_nxt == ST_DONE);
  // Gated by reset so a request held during reset can never write.
  assign w_commit_wr  = i_rst_n & w_enter_done & ~w_op_err & w_op_wr;

  // Sequencer state, wait counter, request capture and registered outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= ST_IDLE;
      r_cnt        <= 3'd0;
      r_done       <= 1'b0;
      r_access_err <= 1'b0;
      r_read_data  <= 32'd0;
      r_rd         <= 1'b0;
      r_wr         <= 1'b0;
      r_sgn        <= 1'b0;
      r_bs         <= 2'b00;
      r_addr       <= '0;
      r_wdata      <= 32'd0;
    end else begin
      r_state      <= w_state_nxt;
      r_done       <= (w_state_nxt == ST_DONE);
      r_access_err <= (w_state_nxt == ST_DONE) & w_op_err;
      if ((r_state == ST_IDLE) && (w_state_nxt == ST_WAIT)) begin
        r_cnt <= WS_INIT;
      end else if ((r_state == ST_WAIT) && (r_cnt != 3'd0)) begin
        r_cnt <= r_cnt - 3'd1;
      end
      if ((r_state == ST_IDLE) && w_req) begin
        r_rd    <= i_mem_read;
        r_wr    <= i_mem_write;
        r_sgn   <= i_load_signed;
        r_bs    <= i_byte_sel;
        r_addr  <= i_address[AW-1:0];
        r_wdata <= i_write_data;
      end
      if (w_enter_done && w_op_rd) begin
        r_read_data <= w_op_err ? 32'd0 : w_load_val;
      end
    end
  end

  // Data memory: byte-lane write on the edge entering DONE; contents are not reset.
  always_ff @(posedge i_clk) begin
    if (w_commit_wr) begin
      for (int b = 0; b < 4; b++) begin
        if (w_store_be[b]) begin
          r_mem[w_op_idx][8*b +: 8] <= w_store_data[8*b +: 8];
        end
      end
    end
  end

  assign o_stall      = ((r_state == ST_IDLE) & w_req) | (r_state == ST_WAIT);
  assign o_done       = r_done;
  assign o_access_err = r_access_err;
  assign o_read_data  = r_read_data;

endmodule

// File: tb/tb_mem_stage_mc.sv
// Bench for mem_stage_mc: three instances (2, 3 and 0 wait states) driven by
// directed and random accesses, checked against a byte-addressed memory model.
module tb_mem_stage_mc;

  logic        clk;
  logic        rst_n;
  logic        mr [3];
  logic        mw [3];
  logic [1:0]  bsel [3];
  logic        sg [3];
  logic [31:0] ad [3];
  logic [31:0] wdat [3];
  logic [31:0] rdata [3];
  logic        stall [3];
  logic        done [3];
  logic        err [3];

  int          ws_tab [3] = '{2, 3, 0};
  logic [31:0] mdl_mem [3][1024];
  logic [31:0] mdl_rd [3];
  int          n_chk = 0;
  int          n_fail = 0;

  mem_stage_mc #(.DEPTH_LOG2(10), .WAIT_STATES(2)) u_ws2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_mem_read(mr[0]), .i_mem_write(mw[0]),
    .i_byte_sel(bsel[0]), .i_load_signed(sg[0]), .i_address(ad[0]), .i_write_data(wdat[0]),
    .o_read_data(rdata[0]), .o_stall(stall[0]), .o_done(done[0]), .o_access_err(err[0]));
  mem_stage_mc #(.DEPTH_LOG2(10), .WAIT_STATES(3)) u_ws3 (
    .i_clk(clk), .i_rst_n(rst_n), .i_mem_read(mr[1]), .i_mem_write(mw[1]),
    .i_byte_sel(bsel[1]), .i_load_signed(sg[1]), .i_address(ad[1]), .i_write_data(wdat[1]),
    .o_read_data(rdata[1]), .o_stall(stall[1]), .o_done(done[1]), .o_access_err(err[1]));
  mem_stage_mc #(.DEPTH_LOG2(10), .WAIT_STATES(0)) u_ws0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_mem_read(mr[2]), .i_mem_write(mw[2]),
    .i_byte_sel(bsel[2]), .i_load_signed(sg[2]), .i_address(ad[2]), .i_write_data(wdat[2]),
    .o_read_data(rdata[2]), .o_stall(stall[2]), .o_done(done[2]), .o_access_err(err[2]));

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Global time bound so the run can never hang.
  initial begin
    #400000;
    $display("FAIL timeout: simulation did not finish, observed running expected finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit mdl_illegal(bit rd, bit wr, bit [1:0] bs, bit [31:0] a);
    return (rd && wr) || (bs == 2'd3) || (bs == 2'd1 && (a % 2) != 0) ||
           (bs == 2'd0 && (a % 4) != 0) || (a >= 32'd4096);
  endfunction

  function automatic int size_of(bit [1:0] bs);
    return (bs == 2'd0) ? 4 : (bs == 2'd1) ? 2 : 1;
  endfunction

  function automatic logic [31:0] mdl_load(int k, bit [1:0] bs, bit sgn, bit [31:0] a);
    logic [31:0] w, mask, v;
    int sz;
    sz   = size_of(bs);
    w    = mdl_mem[k][a / 4];
    mask = (sz == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * sz)) - 32'd1);
    v    = (w >> (8 * (a % 4))) & mask;
    if (sgn && sz < 4 && v[8 * sz - 1]) v = v | ~mask;
    return v;
  endfunction

  task automatic mdl_store(int k, bit [1:0] bs, bit [31:0] a, bit [31:0] wd);
    logic [31:0] mask;
    int sz, sh;
    sz   = size_of(bs);
    sh   = 8 * (a % 4);
    mask = ((sz == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * sz)) - 32'd1)) << sh;
    mdl_mem[k][a / 4] = (mdl_mem[k][a / 4] & ~mask) | ((wd << sh) & mask);
  endtask

  // One access on instance k. rst_cyc >= 1 asserts reset in that cycle of the access.
  task automatic access(int k, bit rd, bit wr, bit [1:0] bs, bit sgn, bit [31:0] a,
                        bit [31:0] wd, int rst_cyc);
    bit ill;
    int done_c;
    ill    = mdl_illegal(rd, wr, bs, a);
    done_c = ill ? 1 : ws_tab[k] + 1;
    @(negedge clk);
    mr[k] = rd; mw[k] = wr; bsel[k] = bs; sg[k] = sgn; ad[k] = a; wdat[k] = wd;
    #1;
    chk("stall_req_cycle", {31'd0, stall[k]}, 32'd1);
    chk("done_req_cycle", {31'd0, done[k]}, 32'd0);
    chk("rdata_hold", rdata[k], mdl_rd[k]);
    @(posedge clk);
    #1;
    mr[k] = 1'($urandom); mw[k] = 1'($urandom); bsel[k] = 2'($urandom);
    sg[k] = 1'($urandom); ad[k] = $urandom; wdat[k] = $urandom;
    for (int c = 1; c <= done_c; c++) begin
      @(negedge clk);
      if (c == rst_cyc) begin
        mr[k] = 1'b0; mw[k] = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rst_stall", {31'd0, stall[k]}, 32'd0);
        chk("rst_done", {31'd0, done[k]}, 32'd0);
        chk("rst_err", {31'd0, err[k]}, 32'd0);
        chk("rst_rdata", rdata[k], 32'd0);
        if (c == done_c && !ill && wr) mdl_store(k, bs, a, wd);
        for (int i = 0; i < 3; i++) mdl_rd[i] = 32'd0;
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      chk("stall_cycle", {31'd0, stall[k]}, {31'd0, (c <= done_c - 1)});
      chk("done_cycle", {31'd0, done[k]}, {31'd0, (c == done_c)});
    end
    mr[k] = 1'b0; mw[k] = 1'b0;
    if (!ill && wr) mdl_store(k, bs, a, wd);
    if (rd) mdl_rd[k] = ill ? 32'd0 : mdl_load(k, bs, sgn, a);
    chk("access_err", {31'd0, err[k]}, {31'd0, ill});
    chk("read_data", rdata[k], mdl_rd[k]);
  endtask

  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      mr[i] = 1'b0; mw[i] = 1'b0; bsel[i] = 2'd0; sg[i] = 1'b0; ad[i] = 32'd0; wdat[i] = 32'd0;
      mdl_rd[i] = 32'd0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk("reset_stall", {31'd0, stall[i]}, 32'd0);
      chk("reset_done", {31'd0, done[i]}, 32'd0);
      chk("reset_err", {31'd0, err[i]}, 32'd0);
      chk("reset_rdata", rdata[i], 32'd0);
    end
    rst_n = 1'b1;

    // Fill the first 16 words of each memory so every later load is defined.
    for (int k = 0; k < 3; k++)
      for (int w = 0; w < 16; w++) access(k, 1'b0, 1'b1, 2'd0, 1'b0, 32'(w * 4), $urandom, -1);

    // Directed lane tests, two wait states.
    access(0, 1'b0, 1'b1, 2'd0, 1'b0, 32'h10, 32'hDEADBEEF, -1);
    access(0, 1'b1, 1'b0, 2'd0, 1'b0, 32'h10, 32'h0, -1);
    chk("plan_word", rdata[0], 32'hDEADBEEF);
    access(0, 1'b0, 1'b1, 2'd2, 1'b0, 32'h11, 32'h0000007F, -1);
    access(0, 1'b1, 1'b0, 2'd0, 1'b0, 32'h10, 32'h0, -1);
    chk("plan_byte_merge", rdata[0], 32'hDEAD7FEF);
    access(0, 1'b1, 1'b0, 2'd2, 1'b1, 32'h13, 32'h0, -1);
    chk("plan_sbyte", rdata[0], 32'hFFFFFFDE);
    access(0, 1'b1, 1'b0, 2'd2, 1'b0, 32'h13, 32'h0, -1);
    chk("plan_ubyte", rdata[0], 32'h000000DE);
    access(0, 1'b0, 1'b1, 2'd1, 1'b0, 32'h12, 32'h00008001, -1);
    access(0, 1'b1, 1'b0, 2'd1, 1'b1, 32'h12, 32'h0, -1);
    chk("plan_shalf", rdata[0], 32'hFFFF8001);
    access(0, 1'b1, 1'b0, 2'd1, 1'b0, 32'h12, 32'h0, -1);
    chk("plan_uhalf", rdata[0], 32'h00008001);

    // Illegal accesses, then confirm the target words are unchanged.
    access(0, 1'b1, 1'b0, 2'd0, 1'b0, 32'h11, 32'h0, -1);
    access(0, 1'b1, 1'b0, 2'd1, 1'b0, 32'h13, 32'h0, -1);
    access(0, 1'b1, 1'b0, 2'd3, 1'b0, 32'h10, 32'h0, -1);
    access(0, 1'b1, 1'b1, 2'd0, 1'b0, 32'h10, 32'h11111111, -1);
    access(0, 1'b1, 1'b0, 2'd0, 1'b0, 32'h1000, 32'h0, -1);
    access(0, 1'b0, 1'b1, 2'd0, 1'b0, 32'h11, 32'h22222222, -1);
    access(0, 1'b0, 1'b1, 2'd1, 1'b0, 32'h13, 32'h33333333, -1);
    access(0, 1'b0, 1'b1, 2'd3, 1'b0, 32'h10, 32'h44444444, -1);
    access(0, 1'b0, 1'b1, 2'd0, 1'b0, 32'h1000, 32'h55555555, -1);
    access(0, 1'b1, 1'b0, 2'd0, 1'b0, 32'h10, 32'h0, -1);
    chk("illegal_no_write", rdata[0], 32'h80017FEF);
    access(0, 1'b1, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0, -1);

    // Reset during the middle WAIT cycle discards the store; reset in DONE keeps it.
    access(1, 1'b0, 1'b1, 2'd0, 1'b0, 32'h20, 32'hCAFEF00D, 2);
    access(1, 1'b1, 1'b0, 2'd0, 1'b0, 32'h20, 32'h0, -1);
    access(1, 1'b0, 1'b1, 2'd0, 1'b0, 32'h24, 32'hA5A55A5A, 4);
    access(1, 1'b1, 1'b0, 2'd0, 1'b0, 32'h24, 32'h0, -1);
    chk("rst_in_done_kept", rdata[1], 32'hA5A55A5A);

    // Zero wait states: back-to-back loads.
    for (int i = 0; i < 4; i++) access(2, 1'b1, 1'b0, 2'd0, 1'b0, 32'(i * 4), 32'h0, -1);

    // Random mix on every instance.
    for (int k = 0; k < 3; k++) begin
      for (int n = 0; n < 40; n++) begin
        int sel;
        bit rd, wr;
        bit [31:0] a;
        sel = $urandom_range(0, 8);
        rd  = (sel <= 3) || (sel == 8);
        wr  = (sel >= 4);
        a   = ($urandom_range(0, 9) == 0) ? ($urandom | 32'h1000) : 32'($urandom_range(0, 63));
        access(k, rd, wr, 2'($urandom), 1'($urandom), a, $urandom, -1);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_stage_mc.md
# mem_stage_mc

Parametrised multi-cycle MEM stage for the MIPS pipeline: owns a word-organised data memory of configurable depth, performs word/halfword/byte loads and stores with sign/zero extension, and inserts a configurable number of wait states per access. It raises Stall toward the hazard unit while an access is in flight and flags illegal accesses instead of corrupting memory. It sits between the EX/MEM and MEM/WB pipeline registers.

## Interface
- DEPTH_LOG2, 10, memory depth in 32-bit words (2^DEPTH_LOG2 words)
- WAIT_STATES, 1, extra cycles per legal access, 0..7
- Clock  in  1  rising-edge clock
- Reset  in  1  asynchronous, active-low reset
- MemRead  in  1  load request
- MemWrite  in  1  store request
- ByteSel  in  2  00 word, 01 halfword, 10 byte, 11 reserved
- LoadSigned  in  1  1 = sign-extend sub-word loads, 0 = zero-extend
- Address  in  32  byte address
- WriteData  in  32  store data; sub-word stores use the low bits
- ReadData  out  32  registered load result
- Stall  out  1  hold the pipeline this cycle
- Done  out  1  one-cycle pulse: access complete
- AccessErr  out  1  qualified by Done: access was illegal, no effect

## Operation
- Req = MemRead | MemWrite. FSM states: IDLE, WAIT, DONE.
- IDLE: Req sampled at the clock edge. An illegal request goes to DONE; a legal one goes to WAIT when WAIT_STATES>0, otherwise to DONE. No Req: stay in IDLE.
- WAIT: a 3-bit counter loads WAIT_STATES-1 on entry and decrements each cycle. Transition to DONE when the counter is 0.
- DONE: always goes to IDLE on the next edge.
- Inputs are captured into internal registers on the IDLE-exit edge. Upstream input changes after that edge are ignored.
- An access is illegal if any of the following holds:
  - MemRead and MemWrite are both high.
  - ByteSel is 11.
  - A halfword access has Address[0]=1.
  - A word access has Address[1:0]≠0.
  - Address[31:DEPTH_LOG2+2]≠0.
- Index = Address[DEPTH_LOG2+1:2]. Little-endian: byte lane = Address[1:0], halfword lane = Address[1].
- Store: the write commits to the addressed lane(s) on the edge entering DONE. The other lanes of the word are preserved.
- Load: the word is read, the lane is selected, then extended per LoadSigned. The result is registered into ReadData on the edge entering DONE.
- Stall = (state==IDLE & Req) | (state==WAIT). Stall is combinational and is 0 in DONE.
- Done = (state==DONE). AccessErr is registered and valid while Done=1.
- ReadData is unchanged by stores and by illegal accesses, except that an illegal load sets ReadData to 0. ReadData holds its value until the next load completes.

## Timing
- Reset values: state IDLE, counter 0, ReadData 0, Done 0, AccessErr 0, Stall 0 (Req=0). Memory contents are not reset.
- Legal access presented in cycle 0: Stall=1 in cycles 0..WAIT_STATES, Done=1 in cycle WAIT_STATES+1. With WAIT_STATES=0, Done is in cycle 1.
- Illegal access: Stall=1 in cycle 0 only. Done=1 and AccessErr=1 in cycle 1. No memory write occurs.
- Back-to-back: the pipeline advances on the edge ending DONE. The next request is seen in IDLE in the following cycle, so no extra bubble is added beyond the wait states.
- Reset asserted mid-access (WAIT or DONE): return immediately to IDLE. A store still in WAIT is discarded. A store already committed in DONE persists.
- A new Req during WAIT or DONE is ignored until IDLE.

## Test plan
- WAIT_STATES=2: store word 0xDEADBEEF at address 0x10, then load word at 0x10. Stall is high for 3 cycles per access, Done occurs in cycle 3, and ReadData=0xDEADBEEF.
- Byte store 0x7F at address 0x11 over 0xDEADBEEF. Word load gives 0xDEAD7FEF. Signed byte load at 0x13 gives 0xFFFFFFDE; unsigned gives 0x000000DE.
- Halfword store 0x8001 at 0x12. Signed halfword load at 0x12 gives 0xFFFF8001; unsigned gives 0x00008001.
- Illegal accesses: word load at 0x11; halfword load at 0x13; ByteSel=11; MemRead=MemWrite=1; address 1<<(DEPTH_LOG2+2). Each gives one Stall cycle, then Done=1 with AccessErr=1, ReadData=0, and the target word unchanged.
- Assert Reset in the middle WAIT cycle of a word store with WAIT_STATES=3. Outputs return to reset values immediately, and a later load of that address returns the old contents.
- WAIT_STATES=0: run 4 back-to-back loads. Done pulses every 2 cycles with Stall=1 exactly in each request cycle.
